// File: rtl/pipe_pkg.sv
// Shared constants and action decode for the pipeline boundary registers.
// Priority order in decode_action is the single source of truth for reset/flush/bubble/load/hold.
package pipe_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int EXC_W_DEF = 32;

  localparam logic [31:0] PC_NOP       = 32'h0000_0000;
  localparam logic [31:0] BADVADDR_NOP = 32'h0000_0000;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_LOAD,
    ACT_HOLD
  } act_e;

  function automatic act_e decode_action(input logic rst, input logic flush,
                                         input logic up, input logic dn);
    if (!rst) return ACT_RESET;
    if (flush) return ACT_FLUSH;
    if (up == STOP && dn == NOSTOP) return ACT_BUBBLE;
    if (up == NOSTOP) return ACT_LOAD;
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; clr beats inc.
// Result visible one cycle after the event; never wraps past all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: payload + exception bundle, 1-cycle latency, no comb input->output path.
// Upstream stall with free downstream inserts a bubble; both stalled holds; flush clears regardless of stall.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int EXC_W      = EXC_W_DEF,
  parameter int STALL_W    = 6,
  parameter int STAGE_IDX  = 4,
  parameter int STICKY_EXC = 1,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic [31:0]        in_pc,
  input  logic [EXC_W-1:0]   in_excepttype,
  input  logic               in_delayslot,
  input  logic [31:0]        in_badvaddr,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_payload,
  output logic [31:0]        out_pc,
  output logic [EXC_W-1:0]   out_excepttype,
  output logic               out_delayslot,
  output logic [31:0]        out_badvaddr,
  output logic               out_kill,
  output logic               exc_pending,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic STICKY_ON = (STICKY_EXC != 0);

  logic up;
  logic dn;
  act_e act;
  logic unused_stall_bits;

  assign up  = stall[STAGE_IDX];
  assign dn  = stall[STAGE_IDX+1];
  assign act = decode_action(rst, flush, up, dn);

  // Only the two stall bits around this boundary matter here.
  assign unused_stall_bits = ^stall;

  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        out_valid      <= 1'b0;
        out_payload    <= '0;
        out_pc         <= PC_NOP;
        out_excepttype <= '0;
        out_delayslot  <= 1'b0;
        out_badvaddr   <= BADVADDR_NOP;
        out_kill       <= 1'b0;
        if (act != ACT_BUBBLE) begin
          exc_pending <= 1'b0;
        end
      end
      ACT_LOAD: begin
        out_valid      <= in_valid;
        out_payload    <= in_payload;
        out_pc         <= in_pc;
        out_excepttype <= in_excepttype;
        out_delayslot  <= in_delayslot;
        out_badvaddr   <= in_badvaddr;
        // The faulting instruction itself sees the old (clear) pending flag.
        out_kill       <= STICKY_ON & exc_pending & in_valid;
        if (STICKY_ON && in_valid && (|in_excepttype)) begin
          exc_pending <= 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (act == ACT_HOLD),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (act == ACT_BUBBLE),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench: three instances (default, STICKY_EXC=0, CNT_W=4) share stimulus.
// Directed table, counter-saturation sequence, then random traffic against a reference model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic         rst;
    logic [5:0]   stall;
    logic         flush;
    logic         cnt_clr;
    logic         valid;
    logic [127:0] payload;
    logic [31:0]  pc;
    logic [31:0]  exc;
    logic         ds;
    logic [31:0]  bva;
  } stim_t;

  typedef struct {
    logic         valid;
    logic [127:0] payload;
    logic [31:0]  pc;
    logic [31:0]  exc;
    logic         ds;
    logic [31:0]  bva;
    logic         kill;
    logic         pend;
    int unsigned  scnt;
    int unsigned  bcnt;
  } mstate_t;

  typedef struct {
    stim_t       st;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_pay;
    logic [31:0] e_exc;
    logic        e_kill;
    logic        e_pend;
    int unsigned e_s;
    int unsigned e_b;
  } vec_t;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic         cnt_clr;
  logic         in_valid;
  logic [127:0] in_payload;
  logic [31:0]  in_pc;
  logic [31:0]  in_excepttype;
  logic         in_delayslot;
  logic [31:0]  in_badvaddr;

  logic         o_valid [3];
  logic [127:0] o_pay   [3];
  logic [31:0]  o_pc    [3];
  logic [31:0]  o_exc   [3];
  logic         o_ds    [3];
  logic [31:0]  o_bva   [3];
  logic         o_kill  [3];
  logic         o_pend  [3];
  logic [15:0]  a_scnt, a_bcnt, b_scnt, b_bcnt;
  logic [3:0]   c_scnt, c_bcnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_reg u_dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc),
    .in_excepttype(in_excepttype), .in_delayslot(in_delayslot), .in_badvaddr(in_badvaddr),
    .out_valid(o_valid[0]), .out_payload(o_pay[0]), .out_pc(o_pc[0]),
    .out_excepttype(o_exc[0]), .out_delayslot(o_ds[0]), .out_badvaddr(o_bva[0]),
    .out_kill(o_kill[0]), .exc_pending(o_pend[0]), .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
  );

  pipe_stage_reg #(.STICKY_EXC(0)) u_dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc),
    .in_excepttype(in_excepttype), .in_delayslot(in_delayslot), .in_badvaddr(in_badvaddr),
    .out_valid(o_valid[1]), .out_payload(o_pay[1]), .out_pc(o_pc[1]),
    .out_excepttype(o_exc[1]), .out_delayslot(o_ds[1]), .out_badvaddr(o_bva[1]),
    .out_kill(o_kill[1]), .exc_pending(o_pend[1]), .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
  );

  pipe_stage_reg #(.CNT_W(4)) u_dut_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc),
    .in_excepttype(in_excepttype), .in_delayslot(in_delayslot), .in_badvaddr(in_badvaddr),
    .out_valid(o_valid[2]), .out_payload(o_pay[2]), .out_pc(o_pc[2]),
    .out_excepttype(o_exc[2]), .out_delayslot(o_ds[2]), .out_badvaddr(o_bva[2]),
    .out_kill(o_kill[2]), .exc_pending(o_pend[2]), .stall_cnt(c_scnt), .bubble_cnt(c_bcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int unsigned get_s(int k);
    if (k == 0) return int'(a_scnt);
    if (k == 1) return int'(b_scnt);
    return int'(c_scnt);
  endfunction

  function automatic int unsigned get_b(int k);
    if (k == 0) return int'(a_bcnt);
    if (k == 1) return int'(b_bcnt);
    return int'(c_bcnt);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    rst           = s.rst;
    stall         = s.stall;
    flush         = s.flush;
    cnt_clr       = s.cnt_clr;
    in_valid      = s.valid;
    in_payload    = s.payload;
    in_pc         = s.pc;
    in_excepttype = s.exc;
    in_delayslot  = s.ds;
    in_badvaddr   = s.bva;
  endtask

  function automatic stim_t mk(logic r, logic [5:0] st, logic fl, logic clr, logic v,
                               logic [31:0] pc, logic [31:0] pay, logic [31:0] exc);
    stim_t s;
    s.rst = r; s.stall = st; s.flush = fl; s.cnt_clr = clr; s.valid = v;
    s.payload = {96'h0, pay}; s.pc = pc; s.exc = exc; s.ds = 1'b0; s.bva = 32'h0;
    return s;
  endfunction

  function automatic vec_t row(logic r, logic [5:0] st, logic fl, logic clr, logic v,
                               logic [31:0] pc, logic [31:0] pay, logic [31:0] exc,
                               logic ev, logic [31:0] epc, logic [31:0] epay, logic [31:0] eexc,
                               logic ek, logic ep, int unsigned es, int unsigned eb);
    vec_t x;
    x.st = mk(r, st, fl, clr, v, pc, pay, exc);
    x.e_valid = ev; x.e_pc = epc; x.e_pay = epay; x.e_exc = eexc;
    x.e_kill = ek; x.e_pend = ep; x.e_s = es; x.e_b = eb;
    return x;
  endfunction

  // Reference: each edge applies the highest-priority rule that matches.
  function automatic mstate_t ref_next(mstate_t s, stim_t i, bit sticky, int unsigned cmax);
    mstate_t n;
    bit up, dn, hold_ev, bub_ev;
    n = s; up = i.stall[4]; dn = i.stall[5]; hold_ev = 0; bub_ev = 0;
    if (!i.rst) begin
      n = '{default: 0};
      return n;
    end
    if (i.flush || (up && !dn)) begin
      n.valid = 0; n.payload = 0; n.pc = 0; n.exc = 0; n.ds = 0; n.bva = 0; n.kill = 0;
      if (i.flush) n.pend = 0;
      else bub_ev = 1;
    end else if (!up) begin
      n.valid = i.valid; n.payload = i.payload; n.pc = i.pc; n.exc = i.exc;
      n.ds = i.ds; n.bva = i.bva;
      n.kill = sticky && s.pend && i.valid;
      if (sticky && i.valid && i.exc != 0) n.pend = 1;
    end else begin
      hold_ev = 1;
    end
    if (i.cnt_clr) begin
      n.scnt = 0; n.bcnt = 0;
    end else begin
      if (hold_ev && n.scnt < cmax) n.scnt++;
      if (bub_ev && n.bcnt < cmax) n.bcnt++;
    end
    return n;
  endfunction

  task automatic check_model(input int k, input string tag, input mstate_t m);
    string p;
    p = $sformatf("%s dut%0d", tag, k);
    chk({p, " valid"}, {127'h0, o_valid[k]}, {127'h0, m.valid});
    chk({p, " payload"}, o_pay[k], m.payload);
    chk({p, " pc"}, {96'h0, o_pc[k]}, {96'h0, m.pc});
    chk({p, " exc"}, {96'h0, o_exc[k]}, {96'h0, m.exc});
    chk({p, " ds"}, {127'h0, o_ds[k]}, {127'h0, m.ds});
    chk({p, " bva"}, {96'h0, o_bva[k]}, {96'h0, m.bva});
    chk({p, " kill"}, {127'h0, o_kill[k]}, {127'h0, m.kill});
    chk({p, " pend"}, {127'h0, o_pend[k]}, {127'h0, m.pend});
    chk({p, " stall_cnt"}, 128'(get_s(k)), 128'(m.scnt));
    chk({p, " bubble_cnt"}, 128'(get_b(k)), 128'(m.bcnt));
  endtask

  vec_t    tbl[$];
  mstate_t m[3];
  bit          sticky_of[3] = '{1'b1, 1'b0, 1'b1};
  int unsigned cmax_of[3]   = '{65535, 65535, 15};

  initial begin
    stim_t s;
    string p;

    drive(mk(1'b0, 6'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));

    // rst stall fl clr v  pc            pay     exc      | valid pc  pay  exc  kill pend s b
    tbl.push_back(row(0, 6'b000000, 0, 0, 1, 32'hBFC00000, 32'hA5, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 0, 0));
    tbl.push_back(row(0, 6'b000000, 0, 0, 1, 32'hBFC00000, 32'hA5, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 0, 0));
    tbl.push_back(row(1, 6'b000000, 0, 0, 1, 32'hBFC00000, 32'hA5, 32'h0,   1, 32'hBFC00000, 32'hA5, 32'h0,   0, 0, 0, 0));
    tbl.push_back(row(1, 6'b010000, 0, 0, 1, 32'hBFC00004, 32'h66, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 0, 1));
    tbl.push_back(row(1, 6'b110000, 0, 0, 1, 32'h00001234, 32'h77, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 1, 1));
    tbl.push_back(row(1, 6'b110000, 0, 0, 1, 32'h00001234, 32'h77, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 2, 1));
    tbl.push_back(row(1, 6'b110000, 0, 0, 1, 32'h00001234, 32'h77, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 3, 1));
    tbl.push_back(row(1, 6'b000000, 0, 0, 1, 32'hBFC00008, 32'h11, 32'h0,   1, 32'hBFC00008, 32'h11, 32'h0,   0, 0, 3, 1));
    tbl.push_back(row(1, 6'b110000, 0, 0, 1, 32'hDEAD0000, 32'h99, 32'h8,   1, 32'hBFC00008, 32'h11, 32'h0,   0, 0, 4, 1));
    tbl.push_back(row(1, 6'b111111, 1, 0, 1, 32'hDEAD0004, 32'h99, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 4, 1));
    tbl.push_back(row(1, 6'b000000, 0, 0, 1, 32'h00000100, 32'h22, 32'h200, 1, 32'h00000100, 32'h22, 32'h200, 0, 1, 4, 1));
    tbl.push_back(row(1, 6'b000000, 0, 0, 1, 32'h00000104, 32'h33, 32'h0,   1, 32'h00000104, 32'h33, 32'h0,   1, 1, 4, 1));
    tbl.push_back(row(1, 6'b010000, 0, 0, 1, 32'hDEAD0008, 32'h99, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 1, 4, 2));
    tbl.push_back(row(1, 6'b000000, 0, 0, 0, 32'h00000108, 32'h44, 32'h0,   0, 32'h00000108, 32'h44, 32'h0,   0, 1, 4, 2));
    tbl.push_back(row(1, 6'b000000, 0, 0, 1, 32'h0000010C, 32'h45, 32'h40,  1, 32'h0000010C, 32'h45, 32'h40,  1, 1, 4, 2));
    tbl.push_back(row(1, 6'b000000, 1, 0, 1, 32'hDEAD000C, 32'h99, 32'h4,   0, 32'h0,        32'h0,  32'h0,   0, 0, 4, 2));
    tbl.push_back(row(1, 6'b000000, 0, 0, 1, 32'h00000110, 32'h55, 32'h0,   1, 32'h00000110, 32'h55, 32'h0,   0, 0, 4, 2));
    tbl.push_back(row(1, 6'b110000, 0, 1, 1, 32'hDEAD0010, 32'h99, 32'h0,   1, 32'h00000110, 32'h55, 32'h0,   0, 0, 0, 0));
    tbl.push_back(row(1, 6'b010000, 0, 1, 1, 32'hDEAD0010, 32'h99, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 0, 0));
    tbl.push_back(row(1, 6'b010000, 0, 0, 1, 32'hDEAD0010, 32'h99, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 0, 1));
    tbl.push_back(row(1, 6'b111111, 0, 0, 1, 32'hDEAD0014, 32'h99, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 1, 1));
    tbl.push_back(row(1, 6'b101111, 0, 0, 1, 32'h00000200, 32'h66, 32'h0,   1, 32'h00000200, 32'h66, 32'h0,   0, 0, 1, 1));
    tbl.push_back(row(0, 6'b110000, 0, 0, 1, 32'hDEAD0018, 32'h99, 32'h0,   0, 32'h0,        32'h0,  32'h0,   0, 0, 0, 0));

    foreach (tbl[r]) begin
      drive(tbl[r].st);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        p = $sformatf("row%0d dut%0d", r, k);
        chk({p, " valid"}, {127'h0, o_valid[k]}, {127'h0, tbl[r].e_valid});
        chk({p, " pc"}, {96'h0, o_pc[k]}, {96'h0, tbl[r].e_pc});
        chk({p, " payload"}, o_pay[k], {96'h0, tbl[r].e_pay});
        chk({p, " exc"}, {96'h0, o_exc[k]}, {96'h0, tbl[r].e_exc});
        chk({p, " kill"}, {127'h0, o_kill[k]}, {127'h0, (k == 1) ? 1'b0 : tbl[r].e_kill});
        chk({p, " pend"}, {127'h0, o_pend[k]}, {127'h0, (k == 1) ? 1'b0 : tbl[r].e_pend});
        chk({p, " stall_cnt"}, 128'(get_s(k)), 128'(tbl[r].e_s));
        chk({p, " bubble_cnt"}, 128'(get_b(k)), 128'(tbl[r].e_b));
      end
    end

    // Counter saturation on the 4-bit instance versus the 16-bit one.
    drive(mk(1'b0, 6'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0));
    @(posedge clk);
    @(negedge clk);
    drive(mk(1'b1, 6'b000000, 1'b0, 1'b0, 1'b1, 32'h300, 32'h77, 32'h0));
    @(posedge clk);
    @(negedge clk);
    for (int i = 1; i <= 20; i++) begin
      drive(mk(1'b1, 6'b110000, 1'b0, 1'b0, 1'b1, 32'hDEAD0000, 32'h99, 32'h0));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat hold%0d c stall_cnt", i), 128'(c_scnt), 128'((i > 15) ? 15 : i));
      chk($sformatf("sat hold%0d a stall_cnt", i), 128'(a_scnt), 128'(i));
    end
    chk("sat hold c pc", {96'h0, o_pc[2]}, 128'h300);
    drive(mk(1'b1, 6'b110000, 1'b0, 1'b1, 1'b1, 32'hDEAD0000, 32'h99, 32'h0));
    @(posedge clk);
    @(negedge clk);
    chk("clr in hold c stall_cnt", 128'(c_scnt), 128'd0);
    chk("clr in hold a stall_cnt", 128'(a_scnt), 128'd0);
    for (int i = 1; i <= 18; i++) begin
      drive(mk(1'b1, 6'b010000, 1'b0, 1'b0, 1'b1, 32'hDEAD0000, 32'h99, 32'h0));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat bub%0d c bubble_cnt", i), 128'(c_bcnt), 128'((i > 15) ? 15 : i));
    end
    drive(mk(1'b1, 6'b000000, 1'b0, 1'b0, 1'b1, 32'h400, 32'h12, 32'h0));
    @(posedge clk);
    drive(mk(1'b1, 6'b110000, 1'b0, 1'b0, 1'b1, 32'hDEAD0000, 32'h99, 32'h0));
    @(posedge clk);
    drive(mk(1'b0, 6'b110000, 1'b0, 1'b0, 1'b1, 32'hDEAD0000, 32'h99, 32'h0));
    @(posedge clk);
    @(negedge clk);
    chk("mid-hold reset c stall_cnt", 128'(c_scnt), 128'd0);
    chk("mid-hold reset c bubble_cnt", 128'(c_bcnt), 128'd0);
    chk("mid-hold reset c valid", {127'h0, o_valid[2]}, 128'h0);
    chk("mid-hold reset c pc", {96'h0, o_pc[2]}, 128'h0);

    // Random traffic against the reference model; the DUTs are in reset here.
    for (int k = 0; k < 3; k++) m[k] = '{default: 0};
    for (int c = 0; c < 3000; c++) begin
      s.rst     = ($urandom_range(0, 199) != 0);
      s.stall   = 6'($urandom);
      s.flush   = ($urandom_range(0, 15) == 0);
      s.cnt_clr = ($urandom_range(0, 39) == 0);
      s.valid   = ($urandom_range(0, 3) != 0);
      s.payload = {$urandom, $urandom, $urandom, $urandom};
      s.pc      = $urandom;
      s.exc     = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      s.ds      = 1'($urandom);
      s.bva     = $urandom;
      drive(s);
      for (int k = 0; k < 3; k++) m[k] = ref_next(m[k], s, sticky_of[k], cmax_of[k]);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) check_model(k, $sformatf("rnd%0d", c), m[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
